// File: rtl/chan_scan_mux.sv
// Registered NCH:1 channel selector with manual select and a dwell-based auto-scan.
// Optional macro CHAN_SKIP_MASK_EN: ch_mask gates channels in both modes and scan skips disabled ones.
module chan_scan_mux #(
    parameter  int unsigned NCH   = 4,
    parameter  int unsigned W     = 1,
    parameter  int unsigned DWELL = 4,
    localparam int unsigned SW    = (NCH < 2) ? 1 : $clog2(NCH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [NCH*W-1:0] din,
    input  logic [SW-1:0]    sel,
    input  logic             mode,
    input  logic [NCH-1:0]   ch_mask,
    output logic [W-1:0]     dout,
    output logic [SW-1:0]    dout_ch,
    output logic             dout_vld,
    output logic             scan_wrap
);

    typedef enum logic {MANUAL, SCAN} state_e;

    state_e         state_q, state_d;
    logic [SW-1:0]  ptr_q, ptr_d;
    logic [7:0]     cnt_q, cnt_d;
    logic           wrap_q, wrap_d;
    logic [W-1:0]   dout_q, dout_d;
    logic [SW-1:0]  dout_ch_q, dout_ch_d;
    logic           dout_vld_q, dout_vld_d;
    logic           scan_wrap_q, scan_wrap_d;

    logic [NCH-1:0] chan_ok;
    logic           any_ok;
    logic           entering;
    logic [SW-1:0]  first_idx, cur_ptr, nxt_ptr;
    logic [7:0]     cur_cnt;
    logic           cur_wrap, nxt_found, sel_hit;
    logic [W-1:0]   sel_dat, ptr_dat;

`ifdef CHAN_SKIP_MASK_EN
    assign chan_ok = ch_mask;
`else
    logic unused_ch_mask;
    assign chan_ok        = '1;
    assign unused_ch_mask = ^ch_mask;
`endif

    assign any_ok = |chan_ok;

    always_comb begin
        first_idx = '0;
        for (int unsigned k = NCH; k > 0; k--) begin
            if (chan_ok[k-1]) first_idx = SW'(k - 1);
        end

        // Entering scan behaves as if ptr/cnt were already reset this cycle.
        entering = mode && (state_q == MANUAL);
        cur_ptr  = entering ? first_idx : ptr_q;
        cur_cnt  = entering ? '0 : cnt_q;
        cur_wrap = entering ? 1'b0 : wrap_q;

        nxt_ptr   = first_idx;
        nxt_found = 1'b0;
        sel_hit   = 1'b0;
        sel_dat   = '0;
        ptr_dat   = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (!nxt_found && chan_ok[k] && (SW'(k) > cur_ptr)) begin
                nxt_ptr   = SW'(k);
                nxt_found = 1'b1;
            end
            if ((SW'(k) == sel) && chan_ok[k]) begin
                sel_hit = 1'b1;
                sel_dat = din[k*W +: W];
            end
            if (SW'(k) == cur_ptr) ptr_dat = din[k*W +: W];
        end
    end

    always_comb begin
        state_d     = mode ? SCAN : MANUAL;
        ptr_d       = '0;
        cnt_d       = '0;
        wrap_d      = 1'b0;
        dout_d      = '0;
        dout_ch_d   = sel;
        dout_vld_d  = 1'b0;
        scan_wrap_d = 1'b0;

        if (!mode) begin
            dout_d     = sel_dat;
            dout_vld_d = sel_hit;
        end else if (!any_ok) begin
            ptr_d     = cur_ptr;
            cnt_d     = cur_cnt;
            wrap_d    = cur_wrap;
            dout_ch_d = cur_ptr;
        end else begin
            dout_d      = ptr_dat;
            dout_ch_d   = cur_ptr;
            dout_vld_d  = 1'b1;
            // wrap_q marks a pointer reached by wrapping; pulse on its first dwell cycle.
            scan_wrap_d = cur_wrap && (cur_cnt == '0);
            if (cur_cnt == 8'(DWELL - 1)) begin
                cnt_d  = '0;
                ptr_d  = nxt_ptr;
                wrap_d = !nxt_found;
            end else begin
                cnt_d  = cur_cnt + 8'd1;
                ptr_d  = cur_ptr;
                wrap_d = cur_wrap;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= MANUAL;
            ptr_q       <= '0;
            cnt_q       <= '0;
            wrap_q      <= 1'b0;
            dout_q      <= '0;
            dout_ch_q   <= '0;
            dout_vld_q  <= 1'b0;
            scan_wrap_q <= 1'b0;
        end else if (ena) begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            wrap_q      <= wrap_d;
            dout_q      <= dout_d;
            dout_ch_q   <= dout_ch_d;
            dout_vld_q  <= dout_vld_d;
            scan_wrap_q <= scan_wrap_d;
        end
    end

    assign dout      = dout_q;
    assign dout_ch   = dout_ch_q;
    assign dout_vld  = dout_vld_q;
    assign scan_wrap = scan_wrap_q;

endmodule

// File: tb/tb_chan_scan_mux.sv
// Bench for chan_scan_mux: per-cycle compare against a scan-time model plus literal spot checks.
// The mask section only builds when CHAN_SKIP_MASK_EN is defined.
module tb_chan_scan_mux;

    localparam int unsigned NCH   = 4;
    localparam int unsigned W     = 4;
    localparam int unsigned DWELL = 2;

    localparam logic [3:0] CH_VAL  [4]  = '{4'h3, 4'h5, 4'hA, 4'hC};
    localparam int         SCAN_CH [11] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0, 1};
    localparam int         U1_CH   [5]  = '{0, 1, 2, 0, 1};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic        mode = 1'b0;
    logic [15:0] din = 16'hCA53;
    logic [1:0]  sel = '0;
    logic [3:0]  ch_mask = '1;
    logic [3:0]  dout;
    logic [1:0]  dout_ch;
    logic        dout_vld, scan_wrap;

    logic [5:0]  din1 = 6'b10_01_11;
    logic [1:0]  sel1 = '0;
    logic        mode1 = 1'b0;
    logic [2:0]  ch_mask1 = '1;
    logic [1:0]  dout1, dout_ch1;
    logic        dout_vld1, scan_wrap1;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    chan_scan_mux #(.NCH(NCH), .W(W), .DWELL(DWELL)) u_dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .din(din), .sel(sel), .mode(mode),
        .ch_mask(ch_mask), .dout(dout), .dout_ch(dout_ch), .dout_vld(dout_vld),
        .scan_wrap(scan_wrap)
    );

    chan_scan_mux #(.NCH(3), .W(2), .DWELL(1)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .din(din1), .sel(sel1), .mode(mode1),
        .ch_mask(ch_mask1), .dout(dout1), .dout_ch(dout_ch1), .dout_vld(dout_vld1),
        .scan_wrap(scan_wrap1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: scan position is a count of enabled scan cycles since entry.
    int unsigned m_t = 0;
    bit          m_scan = 1'b0;
    logic [3:0]  e_dout = '0;
    logic [1:0]  e_ch = '0;
    logic        e_vld = 1'b0, e_wrap = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            e_dout = '0; e_ch = '0; e_vld = 1'b0; e_wrap = 1'b0;
            m_t = 0; m_scan = 1'b0;
        end else if (ena) begin
            if (mode) begin
                if (!m_scan) m_t = 0;
                e_ch   = 2'((m_t / DWELL) % NCH);
                e_wrap = (m_t != 0) && (m_t % (DWELL * NCH) == 0);
                m_t++;
                m_scan = 1'b1;
            end else begin
                e_ch   = sel;
                e_wrap = 1'b0;
                m_scan = 1'b0;
            end
            e_dout = 4'(din >> (32'(e_ch) * 4));
            e_vld  = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_dout", 32'(dout), 32'(e_dout));
            check("model_dout_ch", 32'(dout_ch), 32'(e_ch));
            check("model_dout_vld", 32'(dout_vld), 32'(e_vld));
            check("model_scan_wrap", 32'(scan_wrap), 32'(e_wrap));
        end
    end

    initial begin
        // Reset state
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_dout", 32'(dout), 0);
        check("rst_dout_ch", 32'(dout_ch), 0);
        check("rst_vld", 32'(dout_vld), 0);
        check("rst_wrap", 32'(scan_wrap), 0);
        check("rst_vld3", 32'(dout_vld1), 0);

        // Manual select, one cycle latency; out-of-range select on the 3-channel instance
        rst_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            if (s == 0) sel1 = 2'd3;
            if (s == 1) sel1 = 2'd2;
            tick();
            check("man_dout", 32'(dout), 32'(CH_VAL[s]));
            check("man_ch", 32'(dout_ch), 32'(s));
            check("man_vld", 32'(dout_vld), 1);
            if (s == 0) begin
                check("oor_dout", 32'(dout1), 0);
                check("oor_vld", 32'(dout_vld1), 0);
                check("oor_ch", 32'(dout_ch1), 3);
            end
            if (s == 1) begin
                check("n3_dout", 32'(dout1), 2);
                check("n3_vld", 32'(dout_vld1), 1);
            end
        end

        // Scan with DWELL=2, plus the DWELL=1 instance
        mode  = 1'b1;
        mode1 = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            if (k == 10) din = 16'hCA57;
            tick();
            check("scan_ch", 32'(dout_ch), 32'(SCAN_CH[k-1]));
            check("scan_wrap", 32'(scan_wrap), 32'(k == 9));
            if (k <= 5) begin
                check("d1_ch", 32'(dout_ch1), 32'(U1_CH[k-1]));
                check("d1_wrap", 32'(scan_wrap1), 32'(k == 4));
            end
            if (k == 1) check("d1_dout", 32'(dout1), 3);
            if (k == 10) check("scan_din_track", 32'(dout), 7);
        end

        // Freeze mid-dwell
        ena = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("frz_ch", 32'(dout_ch), 1);
            check("frz_dout", 32'(dout), 5);
            check("frz_vld", 32'(dout_vld), 1);
        end
        ena = 1'b1;
        tick();
        check("resume_ch", 32'(dout_ch), 1);
        tick();
        check("resume_next_ch", 32'(dout_ch), 2);
        check("resume_next_dout", 32'(dout), 32'h0A);

        // Reset mid-scan, restart at channel 0, then leave scan
        rst_n = 1'b0;
        tick();
        check("midrst_vld", 32'(dout_vld), 0);
        check("midrst_ch", 32'(dout_ch), 0);
        check("midrst_dout", 32'(dout), 0);
        rst_n = 1'b1;
        tick();
        check("restart_ch", 32'(dout_ch), 0);
        check("restart_dout", 32'(dout), 7);
        tick();
        tick();
        check("restart_ch1", 32'(dout_ch), 1);
        mode = 1'b0;
        sel  = 2'd2;
        tick();
        check("exit_dout", 32'(dout), 32'h0A);
        check("exit_ch", 32'(dout_ch), 2);
        check("exit_wrap", 32'(scan_wrap), 0);

        // Reset wins over ena=0
        rst_n = 1'b0;
        ena   = 1'b0;
        tick();
        check("rst_over_ena_vld", 32'(dout_vld), 0);
        check("rst_over_ena_ch", 32'(dout_ch), 0);
        rst_n = 1'b1;
        ena   = 1'b1;

        // Mixed directed traffic, checked by the model only
        for (int i = 0; i < 48; i++) begin
            ena  = (i % 5) != 3;
            mode = ((i / 6) % 2) == 1;
            sel  = 2'(i * 3);
            din  = 16'(i * 32'h1357 + 32'h0F0F);
            tick();
        end

`ifdef CHAN_SKIP_MASK_EN
        chk_en = 1'b0;
        ena    = 1'b1;
        mode   = 1'b0;
        din    = 16'hCA53;
        tick();
        ch_mask = 4'b1010;
        mode    = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("mask_ch", 32'(dout_ch), (k <= 2 || k == 5) ? 1 : 3);
            check("mask_wrap", 32'(scan_wrap), 32'(k == 5));
        end
        ch_mask = 4'b0000;
        tick();
        check("mask_none_vld", 32'(dout_vld), 0);
        check("mask_none_dout", 32'(dout), 0);
        ch_mask = 4'b1010;
        mode    = 1'b0;
        sel     = 2'd0;
        tick();
        check("mask_man_off_vld", 32'(dout_vld), 0);
        sel = 2'd1;
        tick();
        check("mask_man_on_dout", 32'(dout), 5);
        check("mask_man_on_vld", 32'(dout_vld), 1);
`endif

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
